// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, FSM states and
// default widths. The external ALU uses the same opcode encoding.
package alu_pkg;

  localparam int DW_DEF = 4;
  localparam int SW_DEF = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_INC = 3'd2;
  localparam logic [2:0] ALU_NOT = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_sched_if.sv
// Request/response bus between the two requesters, the result consumer and
// the scheduler. master = requester/consumer side, slave = scheduler.
interface alu_req_sched_if #(
  parameter int DW = 4,
  parameter int SW = 3
) ();

  logic [1:0]      req_valid;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [2*SW-1:0] req_sel;
  logic [1:0]      req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [DW:0]     rsp_y;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the priority pointer is
// owned and advanced by the parent.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // The pointer side wins when it is requesting, otherwise the other side.
  always_comb begin
    o_grant = 2'b00;
    if (i_req[i_ptr]) begin
      o_grant[i_ptr] = 1'b1;
    end else if (i_req[~i_ptr]) begin
      o_grant[~i_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one external combinational ALU between two requesters.
// IDLE grants one request and latches its operands, EXEC captures the ALU
// result, and RESP holds it until the consumer takes it.
// Optional macro ALU_REQ_SCHED_CHECK_EN adds a reference model that flags
// (sticky chk_err) any ALU result that disagrees for ADD/SUB/INC/NOT.
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  alu_req_sched_if.slave bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW:0]   alu_y,
  output logic          chk_err
);

  state_t        r_state;
  logic          r_prio;
  logic          r_rst_dly;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic [SW-1:0] r_op_sel;
  logic          r_op_id;
  logic [DW:0]   r_rsp_y;
  logic          r_rsp_id;

  logic [1:0]    w_grant;
  logic          w_xfer;
  logic          w_win_id;
  logic [DW-1:0] w_a   [2];
  logic [DW-1:0] w_b   [2];
  logic [SW-1:0] w_sel [2];

  // Unpack the per-requester operand fields.
  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign w_a[gi]   = bus.req_a[gi*DW +: DW];
    assign w_b[gi]   = bus.req_b[gi*SW/SW*DW +: DW];
    assign w_sel[gi] = bus.req_sel[gi*SW +: SW];
  end

  rr_arb2 u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_prio),
    .o_grant (w_grant)
  );

  // Grant only in IDLE, and not during reset or the cycle right after it.
  always_comb begin
    bus.req_ready = 2'b00;
    if (r_state == ST_IDLE && !rst && !r_rst_dly) begin
      bus.req_ready = w_grant;
    end
  end

  assign w_xfer        = |(bus.req_valid & bus.req_ready);
  assign w_win_id      = w_grant[1];
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_id    = r_rsp_id;
  assign alu_a         = r_op_a;
  assign alu_b         = r_op_b;
  assign alu_sel       = r_op_sel;

  // Scheduler FSM: accept, execute for one cycle, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_prio    <= 1'b0;
      r_rst_dly <= 1'b1;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_sel  <= '0;
      r_op_id   <= 1'b0;
      r_rsp_y   <= '0;
      r_rsp_id  <= 1'b0;
    end else begin
      r_rst_dly <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_op_a   <= w_a[w_win_id];
            r_op_b   <= w_b[w_win_id];
            r_op_sel <= w_sel[w_win_id];
            r_op_id  <= w_win_id;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_y  <= alu_y;
          r_rsp_id <= r_op_id;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_prio  <= ~r_rsp_id;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_REQ_SCHED_CHECK_EN
  logic [DW:0] w_exp_y;
  logic        w_chk_valid;
  logic        r_chk_err;

  // Reference model for the defined opcodes; reserved opcodes are skipped.
  always_comb begin
    w_exp_y     = '0;
    w_chk_valid = 1'b1;
    case (r_op_sel)
      ALU_ADD: w_exp_y = {1'b0, r_op_a} + {1'b0, r_op_b};
      ALU_SUB: w_exp_y = {1'b0, r_op_a} - {1'b0, r_op_b};
      ALU_INC: w_exp_y = {1'b0, r_op_a} + {{DW{1'b0}}, 1'b1};
      ALU_NOT: w_exp_y = {1'b0, ~r_op_b};
      default: w_chk_valid = 1'b0;
    endcase
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_err <= 1'b0;
    end else if (r_state == ST_EXEC && w_chk_valid && alu_y != w_exp_y) begin
      r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule
